key_debounce_pulse: RTL and testbench
=====================================

# key_debounce_pulse

Debounces a raw mechanical push-button and produces clean single-cycle event pulses on the 100 MHz system clock. It sits directly upstream of the 1-second hold counter. `press_pulse` drives that counter's `start` input, so one physical press starts exactly one hold window regardless of contact bounce. It also provides a debounced level, a release event, and a one-shot long-press event for the control logic.

## Interface
Parameters:
- `DEB_CYCLES`, default 2_000_000: stable cycles required to accept a level change (20 ms at 100 MHz); legal values are ≥ 2.
- `LONG_CYCLES`, default 100_000_000: cycles in HELD before the long-press event (1 s at 100 MHz); must be greater than 0.
- `KEY_ACTIVE_LOW`, default 1: when 1, `key_in` = 0 means pressed.

Ports:
- `clk`, input, 1: system clock, 100 MHz.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `key_in`, input, 1: raw asynchronous button pin.
- `key_level`, output, 1: debounced state; 1 = pressed.
- `press_pulse`, output, 1: one-cycle pulse on an accepted press.
- `release_pulse`, output, 1: one-cycle pulse on an accepted release.
- `long_press_pulse`, output, 1: one-cycle pulse when the press has been held LONG_CYCLES cycles.

## Operation
- `key_in` passes through a 2-flop synchronizer, then polarity normalisation, giving `key_s` (1 = pressed).
  - Synchronizer flops reset to the released level.
- State machine, reset state IDLE:
  - **IDLE**:
    - `key_s` = 1 → PRESS_DEB, with `deb_cnt` cleared.
  - **PRESS_DEB**:
    - `key_s` = 0 → IDLE, with `deb_cnt` cleared (treated as bounce).
    - `deb_cnt` == DEB_CYCLES-1 with `key_s` = 1 → HELD; `press_pulse` asserts; `long_cnt` cleared.
    - Otherwise `deb_cnt` increments.
  - **HELD**:
    - `key_s` = 0 → REL_DEB, with `deb_cnt` cleared.
    - Otherwise `long_cnt` increments, saturating at LONG_CYCLES.
    - `long_press_pulse` asserts on the cycle `long_cnt` reaches LONG_CYCLES-1. It fires once per press and never repeats.
  - **REL_DEB**:
    - `key_s` = 1 → HELD (bounce). `long_cnt` is retained, not cleared.
    - `deb_cnt` == DEB_CYCLES-1 with `key_s` = 0 → IDLE; `release_pulse` asserts.
- `key_level` = 1 in HELD and REL_DEB, 0 otherwise.
- Counter widths:
  - `deb_cnt` is $clog2(DEB_CYCLES) bits.
  - `long_cnt` is $clog2(LONG_CYCLES+1) bits.
  - Neither counter may wrap.
- If `long_cnt` reaches LONG_CYCLES-1 on the same cycle that HELD→REL_DEB occurs, `long_press_pulse` still asserts.
- Reset mid-operation: all state clears immediately and no pulse is emitted on deassertion. A key already held at reset release must complete a full PRESS_DEB before `press_pulse`.

## Timing
- All outputs are registered. Reset values: `key_level` = 0, `press_pulse` = 0, `release_pulse` = 0, `long_press_pulse` = 0.
- Press latency: with `key_in` stably pressed from rising edge E, `press_pulse` is high during the cycle after edge E+2+DEB_CYCLES. `key_level` rises on the same edge.
  - The 2 cycles are synchronizer delay. DEB_CYCLES is the stability window.
- Release latency is symmetric: `release_pulse` and `key_level` falling occur together, DEB_CYCLES+2 edges after a stable release.
- `long_press_pulse` occurs LONG_CYCLES cycles after `press_pulse`, provided no accepted release intervenes.
  - Bounces that return REL_DEB to HELD do not restart the long-press count.
- All pulses are exactly one cycle wide.
- `press_pulse` and `release_pulse` are never high in the same cycle. The minimum spacing between them is DEB_CYCLES cycles.
- No ready/ack: the downstream stage must sample every cycle.

## Structure
- Shared package `key_pkg`:
  - state enum `key_state_t` {IDLE, PRESS_DEB, HELD, REL_DEB};
  - defaults `DEB_CYCLES_100M` = 2_000_000 and `LONG_CYCLES_100M` = 100_000_000.
- One sub-module, `sync_2ff`: a generic 2-flop synchronizer with async active-low reset and a parameterised reset value. It is reused for other pin inputs.
- Otherwise one always block for the state machine plus counters, and one for the registered outputs.

## Test plan
The bench uses DEB_CYCLES = 8, LONG_CYCLES = 32, KEY_ACTIVE_LOW = 1.

1. Clean press: drive `key_in` 1→0 held → one `press_pulse` 10 cycles later; `key_level` goes to 1; no other pulses.
2. Bounce: toggle `key_in` every 3 cycles for 30 cycles, then hold 0 → no pulse during toggling; exactly one `press_pulse` 10 cycles after the final stable 0.
3. Short press and release: hold 0 for 20 cycles, then 1 → `press_pulse` once; `release_pulse` once, 10 cycles after release; no `long_press_pulse`.
4. Long press: hold 0 for 60 cycles → `long_press_pulse` exactly once, 32 cycles after `press_pulse`; no repeat before release.
5. Release bounce while held: at 20 cycles into HELD, drive a 4-cycle high glitch → no `release_pulse`; `long_press_pulse` still occurs 32 cycles after `press_pulse`.
6. Reset mid-debounce: assert `rst_n` = 0 during PRESS_DEB with the key held → all outputs are 0 during reset. After release of reset, `press_pulse` comes 10 cycles later.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and 100 MHz defaults for the push-button debouncer.
// Exports: key_state_t, DEB_CYCLES_100M, LONG_CYCLES_100M.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        REL_DEB
    } key_state_t;

    // 20 ms debounce window and 1 s long-press time at 100 MHz.
    localparam int DEB_CYCLES_100M  = 2_000_000;
    localparam int LONG_CYCLES_100M = 100_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchronizer for asynchronous pin inputs.
// Ports: clk, rst_n (async, active low), d (async in), q (synced out).
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// Push-button debouncer producing a clean level and one-cycle events.
// Ports: clk, rst_n, key_in (raw pin) -> key_level, press_pulse,
//        release_pulse, long_press_pulse (all registered).
module key_debounce_pulse
    import key_pkg::*;
#(
    parameter int DEB_CYCLES     = DEB_CYCLES_100M,
    parameter int LONG_CYCLES    = LONG_CYCLES_100M,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYCLES);

    logic key_raw_s;
    logic key_s;

    // Synchronizer idles at the released pin level so reset never
    // looks like a press.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (KEY_ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_in),
        .q     (key_raw_s)
    );

    assign key_s = key_raw_s ^ KEY_ACTIVE_LOW;

    key_state_t    state_d;
    key_state_t    state_q;
    logic [DW-1:0] deb_cnt_d;
    logic [DW-1:0] deb_cnt_q;
    logic [LW-1:0] long_cnt_d;
    logic [LW-1:0] long_cnt_q;

    logic key_level_d;
    logic key_level_q;
    logic press_pulse_d;
    logic press_pulse_q;
    logic release_pulse_d;
    logic release_pulse_q;
    logic long_pulse_d;
    logic long_pulse_q;

    always_comb begin
        state_d         = state_q;
        deb_cnt_d       = deb_cnt_q;
        long_cnt_d      = long_cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d   = PRESS_DEB;
                    deb_cnt_d = '0;
                end
            end
            PRESS_DEB: begin
                if (!key_s) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d       = HELD;
                    press_pulse_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_d   = REL_DEB;
                    deb_cnt_d = '0;
                end
            end
            REL_DEB: begin
                if (key_s) begin
                    state_d = HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d         = IDLE;
                    release_pulse_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase

        // long_cnt measures time since the accepted press. It keeps
        // running through release bounces so a glitch neither restarts
        // nor delays the long-press event. Saturating at LONG_CYCLES
        // makes the event one-shot per press.
        if (state_q == HELD || state_q == REL_DEB) begin
            if (long_cnt_q != LONG_SAT) begin
                long_cnt_d = long_cnt_q + 1'b1;
            end
            if (long_cnt_q == LONG_LAST && state_d != IDLE) begin
                long_pulse_d = 1'b1;
            end
        end

        if (press_pulse_d) begin
            long_cnt_d = '0;
        end

        key_level_d = (state_d == HELD) || (state_d == REL_DEB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            long_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            long_cnt_q <= long_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
        end else begin
            key_level_q     <= key_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
        end
    end

    assign key_level        = key_level_q;
    assign press_pulse      = press_pulse_q;
    assign release_pulse    = release_pulse_q;
    assign long_press_pulse = long_pulse_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse (DEB=8, LONG=32, active-low).
// Pulse events are timestamped in posedge counts on the falling edge.
module tb_key_debounce_pulse;

    logic clk;
    logic rst_n;
    logic key_in;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;

    key_debounce_pulse #(
        .DEB_CYCLES     (8),
        .LONG_CYCLES    (32),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .key_in           (key_in),
        .key_level        (key_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_pass = 0;

    int press_n;
    int rel_n;
    int long_n;
    int press_at;
    int rel_at;
    int long_at;
    int both_n  = 0;
    int wide_n  = 0;
    logic prev_p = 1'b0;
    logic prev_r = 1'b0;
    logic prev_l = 1'b0;

    always @(negedge clk) begin
        if (press_pulse) begin
            press_n++;
            press_at = cyc;
        end
        if (release_pulse) begin
            rel_n++;
            rel_at = cyc;
        end
        if (long_press_pulse) begin
            long_n++;
            long_at = cyc;
        end
        if (press_pulse && release_pulse) both_n++;
        if ((press_pulse && prev_p) ||
            (release_pulse && prev_r) ||
            (long_press_pulse && prev_l)) wide_n++;
        prev_p = press_pulse;
        prev_r = release_pulse;
        prev_l = long_press_pulse;
    end

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clr();
        press_n  = 0;
        rel_n    = 0;
        long_n   = 0;
        press_at = -1;
        rel_at   = -1;
        long_at  = -1;
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outs(string tag);
        @(negedge clk);
        check({tag, "_level"}, int'(key_level), 0);
        check({tag, "_press"}, int'(press_pulse), 0);
        check({tag, "_rel"}, int'(release_pulse), 0);
        check({tag, "_long"}, int'(long_press_pulse), 0);
        @(posedge clk);
        #1;
    endtask

    int c;
    int r;

    initial begin
        rst_n  = 1'b0;
        key_in = 1'b1;
        clr();
        wait_cyc(3);
        check_idle_outs("rst");
        rst_n = 1'b1;
        wait_cyc(5);

        // 1 + 4: clean press held 60+ cycles, then release
        clr();
        c = cyc;
        key_in = 1'b0;
        wait_cyc(15);
        check("t1_press_n", press_n, 1);
        check("t1_press_at", press_at, c + 11);
        check("t1_level", int'(key_level), 1);
        check("t1_rel_n", rel_n, 0);
        check("t1_long_n_early", long_n, 0);
        wait_cyc(48);
        check("t4_long_n", long_n, 1);
        check("t4_long_at", long_at, c + 43);
        wait_cyc(20);
        check("t4_no_repeat", long_n, 1);
        c = cyc;
        key_in = 1'b1;
        wait_cyc(15);
        check("t1_rel_n", rel_n, 1);
        check("t1_rel_at", rel_at, c + 11);
        check("t1_level_low", int'(key_level), 0);
        check("t1_press_once", press_n, 1);
        wait_cyc(5);

        // 2: bounce every 3 cycles, then stable press
        clr();
        for (int i = 0; i < 10; i++) begin
            key_in = ~key_in;
            wait_cyc(3);
        end
        check("t2_no_press", press_n, 0);
        check("t2_no_level", int'(key_level), 0);
        c = cyc;
        key_in = 1'b0;
        wait_cyc(15);
        check("t2_press_n", press_n, 1);
        check("t2_press_at", press_at, c + 11);
        key_in = 1'b1;
        wait_cyc(15);
        check("t2_rel_n", rel_n, 1);

        // 3: short press and release
        clr();
        c = cyc;
        key_in = 1'b0;
        wait_cyc(20);
        key_in = 1'b1;
        wait_cyc(45);
        check("t3_press_n", press_n, 1);
        check("t3_press_at", press_at, c + 11);
        check("t3_rel_n", rel_n, 1);
        check("t3_rel_at", rel_at, c + 31);
        check("t3_long_n", long_n, 0);

        // 5: 4-cycle release glitch 20 cycles into HELD
        clr();
        c = cyc;
        key_in = 1'b0;
        wait_cyc(31);
        key_in = 1'b1;
        wait_cyc(4);
        key_in = 1'b0;
        wait_cyc(30);
        check("t5_press_at", press_at, c + 11);
        check("t5_rel_n", rel_n, 0);
        check("t5_level", int'(key_level), 1);
        check("t5_long_n", long_n, 1);
        check("t5_long_at", long_at, c + 43);
        key_in = 1'b1;
        wait_cyc(15);
        check("t5_rel_end", rel_n, 1);

        // 6: reset during PRESS_DEB with key held
        clr();
        key_in = 1'b0;
        wait_cyc(6);
        rst_n = 1'b0;
        wait_cyc(2);
        check_idle_outs("t6_rst");
        check("t6_no_press", press_n, 0);
        r = cyc;
        rst_n = 1'b1;
        wait_cyc(15);
        check("t6_press_n", press_n, 1);
        check("t6_press_at", press_at, r + 11);
        key_in = 1'b1;
        wait_cyc(15);

        check("both_same_cycle", both_n, 0);
        check("pulse_width", wide_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
